// File: rtl/led_scan_pkg.sv
// Shared constants for the 8-digit 7-segment scanner: active-low segment
// codes ({g,f,e,d,c,b,a}, 0 = segment lit) and the digit count.
package led_scan_pkg;

  localparam int DIGITS = 8;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/led_scan_seg7_decode.sv
// Combinational hex-to-7-segment decoder, active-low {g,f,e,d,c,b,a}.
// Lowercase b and d glyphs are used so they are not confused with 8 and 0.
module seg7_decode
  import led_scan_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Table lookup of the glyph for one hex nibble.
  always_comb begin
    seg_o = SEG_BLANK;
    case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/led_scan.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// A scan counter advances the digit index every SCAN_DIV cycles; an
// independent blink counter toggles a blink phase every BLINK_HALF cycles.
// Anode and segment outputs are registered one cycle after the current
// digit index, phase and live inputs. No handshake: inputs are level
// signals sampled every cycle.
module led_scan
  import led_scan_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_HALF = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] led0,
  input  logic [3:0] led1,
  input  logic [3:0] led2,
  input  logic [3:0] led3,
  input  logic [3:0] led4,
  input  logic [3:0] led5,
  input  logic [3:0] led6,
  input  logic [3:0] led7,
  input  logic [7:0] dot,
  input  logic [7:0] blink,
  output logic [7:0] ledCode,
  output logic [7:0] an
);

  localparam int SCAN_W  = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int DIG_W   = $clog2(DIGITS);

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [DIG_W-1:0]   digit_q,     digit_d;
  logic               phase_on_q,  phase_on_d;
  logic [7:0]         an_q,        an_d;
  logic [7:0]         code_q,      code_d;

  logic [3:0] cur_hex;
  logic       cur_dot;
  logic       cur_blink;
  logic [6:0] cur_seg;

  // Counter next-state: scan wraps and advances the digit, blink wraps and
  // toggles the phase; the two never interact.
  always_comb begin
    scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
    digit_d     = digit_q;
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    phase_on_d  = phase_on_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      digit_d    = digit_q + DIG_W'(1);
    end
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_on_d  = ~phase_on_q;
    end
  end

  // Select the live inputs belonging to the digit currently being scanned.
  always_comb begin
    cur_hex = led0;
    case (digit_q)
      3'd0: cur_hex = led0;
      3'd1: cur_hex = led1;
      3'd2: cur_hex = led2;
      3'd3: cur_hex = led3;
      3'd4: cur_hex = led4;
      3'd5: cur_hex = led5;
      3'd6: cur_hex = led6;
      3'd7: cur_hex = led7;
      default: cur_hex = led0;
    endcase
    cur_dot   = dot[digit_q];
    cur_blink = blink[digit_q];
  end

  seg7_decode u_decode (
    .hex_i (cur_hex),
    .seg_o (cur_seg)
  );

  // Output next-state: one anode low and the decoded glyph, or fully dark
  // (decimal point included) when the digit is blinking in the off phase.
  always_comb begin
    an_d   = ~(8'b1 << digit_q);
    code_d = {~cur_dot, cur_seg};
    if (cur_blink && !phase_on_q) begin
      an_d   = 8'hFF;
      code_d = {1'b1, SEG_BLANK};
    end
  end

  // State and output registers; reset restarts both counters and blanks the
  // display on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_q  <= '0;
      blink_cnt_q <= '0;
      digit_q     <= '0;
      phase_on_q  <= 1'b1;
      an_q        <= 8'hFF;
      code_q      <= 8'hFF;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      digit_q     <= digit_d;
      phase_on_q  <= phase_on_d;
      an_q        <= an_d;
      code_q      <= code_d;
    end
  end

  assign an      = an_q;
  assign ledCode = code_q;

endmodule

// File: tb/tb_led_scan.sv
// Self-checking bench for led_scan with SCAN_DIV=4, BLINK_HALF=16.
// The reference model derives the expected display purely from the number
// of edges since reset release: digit = (t / SCAN_DIV) % 8, blink phase is
// OFF when (t / BLINK_HALF) is odd.
module tb_led_scan;

  localparam int SCAN_DIV   = 4;
  localparam int BLINK_HALF = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] leds [8];
  logic [7:0] dot;
  logic [7:0] blink;
  logic [7:0] ledCode;
  logic [7:0] an;

  int checks = 0;
  int errors = 0;
  int t      = 0;

  logic [6:0] seg_tab [16];

  // Clock.
  always #5 clk = ~clk;

  led_scan #(
    .SCAN_DIV   (SCAN_DIV),
    .BLINK_HALF (BLINK_HALF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .led0    (leds[0]),
    .led1    (leds[1]),
    .led2    (leds[2]),
    .led3    (leds[3]),
    .led4    (leds[4]),
    .led5    (leds[5]),
    .led6    (leds[6]),
    .led7    (leds[7]),
    .dot     (dot),
    .blink   (blink),
    .ledCode (ledCode),
    .an      (an)
  );

  function automatic int cur_digit(input int tt);
    return (tt / SCAN_DIV) % 8;
  endfunction

  // Compare both outputs against expected values.
  task automatic check_out(input string tag, input logic [7:0] exp_an,
                           input logic [7:0] exp_code);
    checks++;
    assert (an === exp_an) else begin
      errors++;
      $error("FAIL %s an got %h exp %h (t=%0d)", tag, an, exp_an, t);
    end
    checks++;
    assert (ledCode === exp_code) else begin
      errors++;
      $error("FAIL %s ledCode got %h exp %h (t=%0d)", tag, ledCode, exp_code, t);
    end
  endtask

  // One running edge: predict from the inputs present before the edge.
  task automatic run_cycle(input string tag);
    int d;
    logic       off;
    logic [7:0] e_an, e_code;
    d   = cur_digit(t);
    off = ((t / BLINK_HALF) % 2) == 1;
    if (blink[d] && off) begin
      e_an   = 8'hFF;
      e_code = 8'hFF;
    end else begin
      e_an   = 8'hFF;
      e_an[d] = 1'b0;
      e_code = {~dot[d], seg_tab[leds[d]]};
    end
    @(posedge clk);
    #1;
    check_out(tag, e_an, e_code);
    t++;
  endtask

  // One reset edge: display must be dark, model time restarts.
  task automatic reset_cycle(input string tag);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_out(tag, 8'hFF, 8'hFF);
    t = 0;
  endtask

  task automatic rand_leds();
    for (int i = 0; i < 8; i++) leds[i] = 4'($urandom_range(0, 15));
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    reset = 1'b1;
    dot   = 8'($urandom);
    blink = 8'h00;
    rand_leds();

    // 1. Reset held three cycles, then first digit appears.
    @(negedge clk);
    for (int i = 0; i < 3; i++) reset_cycle("reset_hold");
    reset = 1'b0;
    run_cycle("first_digit");

    // 2. Digits 0..7, no dots, two full scans including the wrap.
    reset_cycle("reset2");
    reset = 1'b0;
    for (int i = 0; i < 8; i++) leds[i] = 4'(i);
    dot = 8'h00;
    for (int i = 0; i < 72; i++) run_cycle("scan_0_7");

    // 3. Digits 8..F with the decimal point on digit 2.
    for (int i = 0; i < 8; i++) leds[i] = 4'(i + 8);
    dot = 8'h04;
    for (int i = 0; i < 40; i++) run_cycle("scan_8_f");

    // 4. Blink on digit 0 across several blink windows.
    rand_leds();
    blink = 8'h01;
    dot   = 8'($urandom);
    for (int i = 0; i < 100; i++) run_cycle("blink0");

    // 5. Random inputs changing every cycle, mid-slot.
    for (int i = 0; i < 200; i++) begin
      rand_leds();
      dot   = 8'($urandom);
      blink = 8'($urandom);
      run_cycle("random");
    end

    // 6. Reset in the middle of digit 5 while every digit blinks; after
    //    release the scan restarts at digit 0 in the ON phase.
    blink = 8'hFF;
    for (int i = 0; i < 64 && !(cur_digit(t) == 5 && (t % SCAN_DIV) == 2); i++)
      run_cycle("to_digit5");
    reset_cycle("reset_mid");
    reset = 1'b0;
    for (int i = 0; i < 40; i++) run_cycle("after_reset");

    // 7. Change led3 mid-slot of digit 3.
    while (!(cur_digit(t) == 3 && (t % SCAN_DIV) == 1)) run_cycle("to_digit3");
    blink   = 8'h00;
    leds[3] = leds[3] ^ 4'h5;
    for (int i = 0; i < 12; i++) run_cycle("led3_change");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
